// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch stage.
package if_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_chk.sv
// Protocol checker: a response while no request is outstanding is an error once traffic has started.
module if_fetch_chk
  import if_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  input fetch_state_e i_state,
  input logic         i_hs,
  input logic         i_rsp_valid
);
  logic r_armed;

  // Arm after the first accepted request so a late response straight after reset is tolerated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_armed <= 1'b0;
    else if (i_hs) r_armed <= 1'b1;
    else           r_armed <= r_armed;
  end

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_armed && i_rsp_valid && (i_state == IDLE || i_state == REQ)));
endmodule

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a flush clear and occupancy count.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_wr_data,
  output fetch_entry_t o_rd_data,
  output logic [CW-1:0] o_count
);
  fetch_entry_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage, pointers and count; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
      else                       r_count <= r_count;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem request, credit-based issue, flush with stale-response drop.
module if_fetch
  import if_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W,
  parameter int INSTR_WIDTH = INSTR_W,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   flush,
  output logic                   go,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e        r_state;
  fetch_state_e        w_next_state;
  logic [PC_WIDTH-1:0] r_pending_pc;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_next_count;
  logic                w_hs;
  logic                w_push;
  logic                w_pop;
  fetch_entry_t        w_wr_entry;
  fetch_entry_t        w_head;

  assign w_hs           = (r_state == REQ) && imem_req_ready;
  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = pc;
  assign go             = flush | w_hs;
  assign if_valid       = (w_count != '0);
  assign w_pop          = if_valid & if_ready & ~flush;
  assign w_push         = (r_state == WAIT) & imem_rsp_valid & ~flush;
  assign w_next_count   = w_count + CW'(w_push) - CW'(w_pop);
  assign w_wr_entry     = '{pc: r_pending_pc, instr: imem_rsp_data};
  assign if_pc          = w_head.pc;
  assign if_instr       = w_head.instr;

  // State and the PC of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pending_pc <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_hs) r_pending_pc <= pc;
      else      r_pending_pc <= r_pending_pc;
    end
  end

  // Next state; flush overrides, and an accepted or unanswered request turns into a DROP.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      case (r_state)
        IDLE:    w_next_state = REQ;
        REQ:     w_next_state = w_hs ? DROP : REQ;
        WAIT:    w_next_state = imem_rsp_valid ? REQ : DROP;
        DROP:    w_next_state = imem_rsp_valid ? REQ : DROP;
        default: w_next_state = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count < CW'(FIFO_DEPTH)) w_next_state = REQ;
          else                           w_next_state = IDLE;
        end
        REQ:  w_next_state = imem_req_ready ? WAIT : REQ;
        WAIT: begin
          if (!imem_rsp_valid)                       w_next_state = WAIT;
          else if (w_next_count < CW'(FIFO_DEPTH))   w_next_state = REQ;
          else                                       w_next_state = IDLE;
        end
        DROP:    w_next_state = imem_rsp_valid ? REQ : DROP;
        default: w_next_state = IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (flush),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_wr_entry),
    .o_rd_data (w_head),
    .o_count   (w_count)
  );

  if_fetch_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_state     (r_state),
    .i_hs        (w_hs),
    .i_rsp_valid (imem_rsp_valid)
  );
endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: the bench acts as PC unit and memory, and tracks expected decode traffic with queues.
module tb_if_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        flush;
  logic        go;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  if_fetch #(.PC_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush), .go(go),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t       pend[$];     // accepted requests awaiting a response, oldest first
  logic [31:0] exp_q[$];    // PCs expected at the decode interface, head first
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          idle_run = 0;
  int          p_ready = 100, p_ifready = 100, p_flush = 0, lat_min = 1, lat_max = 1;
  logic [31:0] next_pc = 32'd0;
  logic [31:0] prev_addr = 32'd0;
  logic        prev_stall = 1'b0;
  logic        stale_inj = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic set_mode(input int rdy, input int ifr, input int fl, input int lmin, input int lmax);
    p_ready = rdy; p_ifready = ifr; p_flush = fl; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic cycle();
    logic        hs;
    logic        rsp_real;
    logic [31:0] tgt;
    pend_t       e;
    @(negedge clk);
    cyc++;
    pc             = next_pc;
    flush          = ($urandom_range(99) < p_flush);
    imem_req_ready = ($urandom_range(99) < p_ready);
    if_ready       = ($urandom_range(99) < p_ifready);
    tgt            = 32'h0000_0100 + 32'($urandom_range(1023)) * 32'd4;
    rsp_real       = 1'b0;
    if (stale_inj) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend[0].addr);
      rsp_real       = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    chk("go", go, flush | (imem_req_valid & imem_req_ready));
    chk("if_valid", if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("if_pc", if_pc, exp_q[0]);
      chk("if_instr", if_instr, instr_of(exp_q[0]));
    end
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, pc);
      chk("credit", (exp_q.size() + pend.size()) < DEPTH, 1);
    end
    if (prev_stall) begin
      chk("req_hold", imem_req_valid, 1);
      chk("req_addr_hold", imem_req_addr, prev_addr);
    end
    if (stale_inj) chk("stale_idle", imem_req_valid, 0);
    if (pend.size() == 0 && exp_q.size() < DEPTH && !imem_req_valid) idle_run++;
    else idle_run = 0;
    chk("req_stall", idle_run > 2, 0);

    // Apply this cycle's events to the model as the clock edge will.
    hs         = imem_req_valid & imem_req_ready;
    prev_stall = imem_req_valid & ~imem_req_ready & ~flush;
    prev_addr  = imem_req_addr;
    if (exp_q.size() != 0 && if_ready && !flush) void'(exp_q.pop_front());
    if (rsp_real) begin
      e = pend.pop_front();
      if (!flush && e.epoch == epoch) exp_q.push_back(e.addr);
    end
    if (hs) begin
      e.addr  = pc;
      e.epoch = epoch;
      e.due   = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back(e);
    end
    if (flush) begin
      exp_q.delete();
      epoch++;
    end
    next_pc   = flush ? tgt : (hs ? pc + 32'd4 : pc);
    stale_inj = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; if_ready = 1'b0;
    #1;
    chk("rst_go", go, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    pend.delete();
    exp_q.delete();
    pc = 32'd0; next_pc = 32'd0; prev_stall = 1'b0; idle_run = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pc = 32'd0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; if_ready = 1'b0;
    apply_reset();

    set_mode(100, 100, 0, 1, 1);  repeat (40)  cycle();
    set_mode(100,   0, 0, 1, 1);  repeat (15)  cycle();
    chk("fifo_full", exp_q.size(), DEPTH);
    set_mode(100, 100, 0, 1, 1);  repeat (10)  cycle();
    set_mode( 30, 100, 0, 1, 2);  repeat (60)  cycle();
    set_mode(100, 100, 10, 1, 3); repeat (150) cycle();
    set_mode( 70,  60, 8, 1, 3);  repeat (300) cycle();

    set_mode(100, 100, 0, 2, 3);
    for (int g = 0; g < 50 && pend.size() == 0; g++) cycle();
    chk("rst_mid_pending", pend.size() != 0, 1);
    apply_reset();
    stale_inj = 1'b1;
    cycle();
    cycle();
    chk("rst_first_req", imem_req_valid, 1);
    chk("rst_first_addr", imem_req_addr, 0);
    repeat (30) cycle();

    set_mode(60, 70, 12, 1, 3);   repeat (300) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
